// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port seen by mem_arbiter.
// slave = arbiter side, master = the environment driving requests and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port: data has priority, fetch is
// forced through after STARVE_LIMIT denied cycles; fixed one-cycle read response.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int                CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic              OWN_FETCH  = 1'b0;
    localparam logic              OWN_DATA   = 1'b1;
    localparam logic [DATA_W-1:0] ZERO_D     = '0;
    localparam logic [ADDR_W-1:0] ZERO_A     = '0;

    logic             r_hold;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_resp_pend;
    logic             r_resp_owner;
    logic             r_resp_store;

    logic                  w_block;
    logic                  w_any;
    logic                  w_fetch_win;
    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic                  w_accept;
    logic                  w_if_rvalid;
    logic                  w_d_rvalid;
    logic                  w_mem_req;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic [DATA_W/8-1:0]   w_mem_be;

    // Outputs are squelched while reset is low and for the first cycle after release.
    assign w_block     = !reset || r_hold;
    assign w_any       = (bus.if_req || bus.d_req) && !w_block;
    assign w_fetch_win = bus.if_req && (!bus.d_req || (r_starve_cnt == STARVE_MAX));
    assign w_if_gnt    = w_any &&  w_fetch_win && bus.mem_ready;
    assign w_d_gnt     = w_any && !w_fetch_win && bus.mem_ready;
    assign w_accept    = w_if_gnt || w_d_gnt;

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = ZERO_A;
        w_mem_wdata = ZERO_D;
        w_mem_be    = '0;
        if (w_any) begin
            w_mem_req = 1'b1;
            if (w_fetch_win) begin
                w_mem_addr = bus.if_addr;
                w_mem_be   = {(DATA_W/8){1'b1}};
            end else begin
                w_mem_we    = bus.d_we;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
                w_mem_be    = bus.d_be;
            end
        end
    end

    assign w_if_rvalid = r_resp_pend && (r_resp_owner == OWN_FETCH) && !w_block;
    assign w_d_rvalid  = r_resp_pend && (r_resp_owner == OWN_DATA)  && !w_block;

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_be    = w_mem_be;
    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = w_if_rvalid;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : ZERO_D;
    assign bus.d_rdata   = (w_d_rvalid && !r_resp_store) ? bus.mem_rdata : ZERO_D;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold       <= 1'b1;
            r_starve_cnt <= '0;
            r_resp_pend  <= 1'b0;
            r_resp_owner <= OWN_FETCH;
            r_resp_store <= 1'b0;
        end else begin
            r_hold      <= 1'b0;
            r_resp_pend <= w_accept;
            if (w_accept) begin
                r_resp_owner <= w_if_gnt ? OWN_FETCH : OWN_DATA;
                r_resp_store <= w_d_gnt && bus.d_we;
            end
            if (!bus.if_req || w_if_gnt)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of both requester ports and memory port.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive cycles fetch may be denied before it is forced to win.
REQ-004 clk  in  1  single clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; sampled only on a rising clk edge.
REQ-006 if_req  in  1  fetch port request; held with if_addr until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch byte address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  data port request; held with d_we/d_addr/d_wdata/d_be until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data byte address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_be  in  DATA_W/8  store byte enables.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  data response valid (loads and stores).
REQ-018 d_rdata  out  DATA_W  load data; 0 on store responses.
REQ-019 mem_req  out  1  memory access request.
REQ-020 mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  access fields from winning port; fetch drives mem_we=0, mem_be=all ones.
REQ-021 mem_ready  in  1  memory accepts the access in the cycle mem_req and mem_ready are both 1.
REQ-022 mem_rdata  in  DATA_W  read data, valid exactly one cycle after acceptance.

Function
REQ-023 Winner selection is combinational each cycle; mem_req = if_req | d_req; memory fields come from the winner.
REQ-024 Default priority: data port wins when d_req = 1.
REQ-025 starve_cnt (clog2(STARVE_LIMIT+1) bits) increments each cycle if_req = 1 and if_gnt = 0, saturating at STARVE_LIMIT; clears when if_gnt = 1 or if_req = 0.
REQ-026 When starve_cnt == STARVE_LIMIT and if_req = 1, fetch wins even if d_req = 1.
REQ-027 Winner's gnt = mem_ready; loser's gnt = 0; both gnt = 0 when mem_ready = 0 (requests held, winner re-evaluated next cycle).
REQ-028 On acceptance, resp_owner register records port (FETCH/DATA) and is_store; resp_pend set to 1; otherwise resp_pend cleared next cycle.
REQ-029 Cycle after acceptance: owner's rvalid = 1 for exactly one cycle; other rvalid = 0.
REQ-030 Fetch/load response: owner rdata = mem_rdata; store response: d_rdata = 0.
REQ-031 Non-owner rdata = 0; rdata = 0 whenever rvalid = 0.
REQ-032 Back-to-back acceptances allowed every cycle; throughput one access per cycle; response latency fixed at 1 cycle.
REQ-033 Simultaneous response and new acceptance in same cycle are independent (response for N, grant for N+1).
REQ-034 No request: mem_req = 0, mem fields = 0, both gnt = 0.

Reset
REQ-035 While reset = 0 at a clk edge: starve_cnt = 0, resp_pend = 0, resp_owner = FETCH.
REQ-036 During and one cycle after reset: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req all 0, rdata outputs 0, regardless of requests.
REQ-037 Reset asserted with a response pending drops that response; no rvalid emitted after reset release.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x4, mem_ready=1, mem_rdata=0x00200113 next cycle -> if_gnt=1, then if_rvalid=1, if_rdata=0x00200113.
REQ-039 Contention: if_req=d_req=1, d_we=0, d_addr=0x100, mem_ready=1 -> d_gnt cycle 0; load response cycle 1; if_gnt not before cycle 3 with STARVE_LIMIT=3.
REQ-040 Starvation: d_req held 1 for 10 cycles with if_req=1 -> fetch granted on every 4th cycle (starve_cnt reaches 3), data on others.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=0xF -> mem_we=1, fields match, d_gnt=1; next cycle d_rvalid=1, d_rdata=0.
REQ-042 Stall: mem_ready=0 for 3 cycles with d_req=1 -> no gnt, no rvalid; mem_ready=1 -> d_gnt that cycle, d_rvalid next.
REQ-043 Reset mid-op: acceptance at cycle N, reset=0 at cycle N+1 edge -> no rvalid at any later cycle, starve_cnt = 0.
